// File: rtl/uart_pkg.sv
// Shared UART constants: data width and default receive FIFO depth.
// No logic, no latency.
// No flow control; constants only.
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int UART_RX_FIFO_DEPTH_DEF = 16;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: one write port, one async read port.
// Write lands on the rising edge; read is combinational from the address.
// No flow control; the caller decides when writes are legal.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [UART_DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]          raddr_i,
    output logic [UART_DATA_W-1:0] rdata_o
);

    // Contents are intentionally not reset; stale entries are masked by the FIFO.
    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    // Single write port, clocked.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver; writes on rx_done rising edge, FWFT read side.
// Latency: byte written in cycle N is visible on rd_data/rd_valid in cycle N+1.
// Backpressure: rd_ready stalls the head; writes to a full FIFO without a same-cycle pop
// are dropped (sticky ovf flag when UART_RX_FIFO_ERR_EN is defined).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = UART_RX_FIFO_DEPTH_DEF,
    parameter int AF_THRESH = 12
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [UART_DATA_W-1:0]   rx_DATA,
    input  logic                     rx_done,
    output logic [UART_DATA_W-1:0]   rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
`ifdef UART_RX_FIFO_ERR_EN
    output logic                     almost_full,
    output logic                     ovf,
    input  logic                     ovf_clr
`else
    output logic                     almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          rx_done_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, afull_q, rd_valid_q;
    logic          wr_req, push, pop;
    logic [UART_DATA_W-1:0] mem_rdata;

    // Strobe may be a level lasting several cycles; only its rising edge is a write.
    assign wr_req = rx_done & ~rx_done_q;
    assign pop    = rd_valid_q & rd_ready;
    // When full, a write only fits if the head leaves in the same cycle.
    assign push   = wr_req & (~full_q | pop);

    // Next occupancy from this cycle's push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Edge detector, pointers and registered status; rx_done_q resets high so a
    // strobe already asserted at reset release is not taken as a new byte.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_done_q  <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rx_done_q  <= rx_done;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            full_q     <= (count_d == CW'(DEPTH));
            afull_q    <= (count_d >= CW'(AF_THRESH));
            rd_valid_q <= (count_d != '0);
        end
    end

`ifdef UART_RX_FIFO_ERR_EN
    logic drop;
    logic ovf_q;
    assign drop = wr_req & full_q & ~pop;

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end
    assign ovf = ovf_q;
`endif

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clock),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (rx_DATA),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    // Mask the unreset array so an empty FIFO always presents zero.
    assign rd_data     = rd_valid_q ? mem_rdata : '0;
    assign rd_valid    = rd_valid_q;
    assign count       = count_q;
    assign full        = full_q;
    assign almost_full = afull_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, storage entries; power of two, 4..256.
REQ-002 SHALL have parameter AF_THRESH, default 12, almost_full asserts when count >= AF_THRESH.
REQ-003 SHALL have port clock  in  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_DATA  in  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_done  in  1  byte-complete strobe from the UART receiver, level may last >1 cycle.
REQ-007 SHALL have port rd_data  out  8  head-of-queue byte, first-word-fall-through.
REQ-008 SHALL have port rd_valid  out  1  high when count != 0.
REQ-009 SHALL have port rd_ready  in  1  consumer accepts rd_data when rd_valid & rd_ready.
REQ-010 SHALL have port count  out  $clog2(DEPTH)+1  bytes stored.
REQ-011 SHALL have port full  out  1  count == DEPTH.
REQ-012 SHALL have port almost_full  out  1  count >= AF_THRESH.
REQ-013 SHALL have ports ovf (out, 1, sticky overflow) and ovf_clr (in, 1, clears ovf) only when UART_RX_FIFO_ERR_EN is defined.

Function
REQ-014 SHALL detect write requests as rising edges of rx_done (rx_done & ~rx_done_q), one write per edge regardless of pulse length.
REQ-015 SHALL capture rx_DATA in the same cycle the edge is detected.
REQ-016 SHALL make a byte written in cycle N visible on rd_data/rd_valid from cycle N+1 when the FIFO was empty.
REQ-017 SHALL pop exactly one byte per cycle with rd_valid & rd_ready; rd_data SHALL then show the next entry the following cycle.
REQ-018 SHALL ignore rd_ready when rd_valid is low; count never underflows.
REQ-019 SHALL accept a write when full only if a pop occurs in the same cycle; count then stays DEPTH.
REQ-020 SHALL drop a write when full with no same-cycle pop; stored data and pointers unchanged.
REQ-021 SHALL keep count unchanged on simultaneous write and pop when not empty; on empty, write-only takes effect (no bypass).
REQ-022 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-023 SHALL register full, almost_full and count, consistent with stored contents every cycle.

Reset
REQ-024 SHALL, on reset_n low, asynchronously clear pointers, count, full, almost_full, rd_valid, and ovf; rd_data SHALL read 8'h00.
REQ-025 SHALL reset rx_done_q to 1, so an rx_done level present at reset release produces no write.
REQ-026 SHALL not clear memory contents on reset; contents are unobservable until rewritten.
REQ-027 SHALL, on reset mid-operation, discard all buffered bytes and resume from empty on the first clock after release.

Configuration
REQ-028 SHALL, with UART_RX_FIFO_ERR_EN defined, set ovf on any dropped write (REQ-020) and hold it until an ovf_clr cycle; a drop coincident with ovf_clr SHALL leave ovf set.
REQ-029 SHALL, without UART_RX_FIFO_ERR_EN, omit ovf and ovf_clr and drop overflow writes silently.

Structure
REQ-030 SHALL take UART_DATA_W (8) and UART_RX_FIFO_DEPTH_DEF (16) from shared package uart_pkg.
REQ-031 SHALL place the storage array in sub-module uart_fifo_mem (one write port, one asynchronous read port).

Verification
REQ-032 SHALL cover: reset, rx_done pulse with rx_DATA=8'hA5 -> next cycle rd_valid=1, rd_data=8'hA5, count=1.
REQ-033 SHALL cover: rx_done held high 5 cycles with 8'h3C -> exactly one entry, count=1.
REQ-034 SHALL cover: 16 writes 8'h00..8'h0F, rd_ready=0 -> full=1, almost_full=1 from the 12th; 17th write 8'hFF dropped, ovf=1 (macro on); drain reads 8'h00..8'h0F in order.
REQ-035 SHALL cover: full FIFO, write 8'h77 plus pop in same cycle -> count stays 16, 8'h77 read last.
REQ-036 SHALL cover: 40 write/read cycles with 8'h10..8'h37 -> pointer wrap, output sequence identical to input.
REQ-037 SHALL cover: reset_n pulsed low with count=7 -> count=0, rd_valid=0, full=0 immediately, no clock edge required.
